// File: rtl/temp_text_formatter.sv
// Stability-filtered BCD temperature to 6-char ASCII field streamer.
// Optional min/max tracking via TEMP_MINMAX_EN.
module temp_text_formatter #(
  parameter int STABLE_CYCLES = 27000,
  parameter int CNT_W         = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] temperature,
  input  logic        refresh,
  output logic [7:0]  char_data,
  output logic [2:0]  char_pos,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] min_temp,
  output logic [15:0] max_temp
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

  function automatic logic word_ok(input logic [15:0] w);
    word_ok = (w[15:12] < 4'd2) && (w[11:8] < 4'd10) &&
              (w[7:4] < 4'd10) && (w[3:0] < 4'd10);
  endfunction

  function automatic logic [7:0] glyph(input logic [15:0] w,
                                       input logic [2:0]  p);
    logic ok;
    ok = word_ok(w);
    glyph = 8'h20;
    case (p)
      3'd0: glyph = (ok && w[12]) ? 8'h2D : 8'h20;
      3'd1: glyph = !ok ? 8'h2D :
                    (w[11:8] == 4'd0) ? 8'h20 : {4'h3, w[11:8]};
      3'd2: glyph = ok ? {4'h3, w[7:4]} : 8'h2D;
      3'd3: glyph = 8'h2E;
      3'd4: glyph = ok ? {4'h3, w[3:0]} : 8'h2D;
      3'd5: glyph = 8'h43;
      default: glyph = 8'h20;
    endcase
  endfunction

  logic [15:0]      cand_q, cand_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      snap_q, snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             have_q, have_d;
  logic             pend_q, pend_d;
  logic [1:0]       state_q, state_d;
  logic [2:0]       pos_q, pos_d;
  logic             valid_q, valid_d;
  logic [7:0]       char_q, char_d;
  logic             same;
  logic             accept;
  logic             set_pend;

  // Stability filter, pending tracking, frame FSM and character mapping
  always_comb begin
    same     = (temperature == cand_q);
    cand_d   = temperature;
    cnt_d    = '0;
    if (same)
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    accept   = same && (cnt_q == CNT_PRE) &&
               (!have_q || (cand_q != acc_q));
    acc_d    = accept ? cand_q : acc_q;
    have_d   = have_q | accept;
    set_pend = accept | (refresh & have_q);
    pend_d   = pend_q | set_pend;
    state_d  = state_q;
    snap_d   = snap_q;
    pos_d    = pos_q;
    valid_d  = valid_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (pend_q) begin
          snap_d  = acc_q;
          pend_d  = set_pend;
          pos_d   = 3'd0;
          valid_d = 1'b1;
          state_d = S_EMIT;
        end
      end
      (state_q == S_EMIT): begin
        if (valid_q && char_ready) begin
          if (pos_q == 3'd5) begin
            valid_d = 1'b0;
            state_d = S_DONE;
          end else begin
            pos_d = pos_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    char_d = glyph(snap_d, pos_d);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q  <= '0;
      acc_q   <= '0;
      snap_q  <= '0;
      cnt_q   <= '0;
      have_q  <= 1'b0;
      pend_q  <= 1'b0;
      state_q <= S_IDLE;
      pos_q   <= 3'd0;
      valid_q <= 1'b0;
      char_q  <= 8'h20;
    end else begin
      cand_q  <= cand_d;
      acc_q   <= acc_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      have_q  <= have_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      char_q  <= char_d;
    end
  end

  assign char_data  = char_q;
  assign char_pos   = pos_q;
  assign char_valid = valid_q;
  assign busy       = (state_q == S_EMIT);
  assign frame_done = (state_q == S_DONE);

`ifdef TEMP_MINMAX_EN
  function automatic logic signed [10:0] tval(input logic [15:0] w);
    logic [10:0] m;
    m = 11'(w[11:8]) * 11'd100 + 11'(w[7:4]) * 11'd10 + 11'(w[3:0]);
    tval = w[12] ? -$signed(m) : $signed(m);
  endfunction

  logic [15:0] min_q, min_d;
  logic [15:0] max_q, max_d;
  logic        mm_have_q, mm_have_d;

  // Fold each valid acceptance into the running extremes; ties keep old word
  always_comb begin
    min_d     = min_q;
    max_d     = max_q;
    mm_have_d = mm_have_q;
    if (accept && word_ok(cand_q)) begin
      mm_have_d = 1'b1;
      if (!mm_have_q) begin
        min_d = cand_q;
        max_d = cand_q;
      end else begin
        if (tval(cand_q) < tval(min_q))
          min_d = cand_q;
        if (tval(cand_q) > tval(max_q))
          max_d = cand_q;
      end
    end
  end

  // Min/max registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q     <= '0;
      max_q     <= '0;
      mm_have_q <= 1'b0;
    end else begin
      min_q     <= min_d;
      max_q     <= max_d;
      mm_have_q <= mm_have_d;
    end
  end

  assign min_temp = min_q;
  assign max_temp = max_q;
`else
  assign min_temp = '0;
  assign max_temp = '0;
`endif

endmodule

// File: tb/tb_temp_text_formatter.sv
// Scoreboard bench for temp_text_formatter.
// Expected frames queued by stimulus, popped by a negedge monitor.
module tb_temp_text_formatter;

  localparam int S = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] temperature;
  logic        refresh;
  logic [7:0]  char_data;
  logic [2:0]  char_pos;
  logic        char_valid;
  logic        char_ready;
  logic        frame_done;
  logic        busy;
  logic [15:0] min_temp;
  logic [15:0] max_temp;

  temp_text_formatter #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .temperature(temperature),
    .refresh(refresh), .char_data(char_data), .char_pos(char_pos),
    .char_valid(char_valid), .char_ready(char_ready),
    .frame_done(frame_done), .busy(busy),
    .min_temp(min_temp), .max_temp(max_temp)
  );

  always #5 clk = ~clk;

  logic [10:0] q[$];
  int total = 0;
  int bad = 0;
  int frames = 0;
  logic stall = 1'b0;
  logic [7:0] pd;
  logic [2:0] pp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++)
      q.push_back({3'(i), f[47-8*i -: 8]});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall && char_valid) begin
        chk("hold_data", {24'd0, char_data}, {24'd0, pd});
        chk("hold_pos", {29'd0, char_pos}, {29'd0, pp});
      end
      if (char_valid && char_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_char: got pos=%0d ch=%0h want none",
                   char_pos, char_data);
        end else begin
          logic [10:0] e;
          e = q.pop_front();
          chk("char", {21'd0, char_pos, char_data}, {21'd0, e});
        end
      end
      if (frame_done) frames++;
      stall = char_valid && !char_ready;
      pd = char_data;
      pp = char_pos;
    end
  end

  task automatic drain(input bit toggle);
    int n = 0;
    while ((q.size() != 0 || busy || char_valid || frame_done) && n < 300) begin
      @(posedge clk);
      #1;
      char_ready = toggle ? ~char_ready : 1'b1;
      n++;
    end
    chk("drain_timeout", n < 300, 1);
    repeat (4) @(posedge clk);
    #1;
    char_ready = 1'b1;
  endtask

  task automatic chk_reset();
    chk("rst_valid", {31'd0, char_valid}, 0);
    chk("rst_data", {24'd0, char_data}, 32'h20);
    chk("rst_pos", {29'd0, char_pos}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    chk("rst_min", {16'd0, min_temp}, 0);
    chk("rst_max", {16'd0, max_temp}, 0);
  endtask

  task automatic chk_mm(input string nm, input logic [15:0] mn,
                        input logic [15:0] mx);
`ifdef TEMP_MINMAX_EN
    chk({nm, "_min"}, {16'd0, min_temp}, {16'd0, mn});
    chk({nm, "_max"}, {16'd0, max_temp}, {16'd0, mx});
`else
    chk({nm, "_min"}, {16'd0, min_temp}, {16'd0, mn & 16'h0});
    chk({nm, "_max"}, {16'd0, max_temp}, {16'd0, mx & 16'h0});
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int f0;
    rst_n = 1'b0;
    temperature = 16'h0235;
    refresh = 1'b0;
    char_ready = 1'b1;
    #12;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;

    push_frame(48'h20_32_33_2E_35_43);
    drain(0);
    chk("frames_a", frames, 1);
    repeat (3*S) @(posedge clk);
    #1;
    chk("no_repeat", frames, 1);
    chk_mm("mm_a", 16'h0235, 16'h0235);

    temperature = 16'h1057;
    push_frame(48'h2D_20_35_2E_37_43);
    drain(1);
    chk("frames_b", frames, 2);
    chk_mm("mm_b", 16'h1057, 16'h0235);

    temperature = 16'h0235;
    push_frame(48'h20_32_33_2E_35_43);
    drain(0);
    temperature = 16'h0240;
    repeat (S-1) @(posedge clk);
    #1;
    temperature = 16'h0235;
    repeat (3*S) @(posedge clk);
    #1;
    chk("glitch", frames, 3);
    temperature = 16'h0240;
    push_frame(48'h20_32_34_2E_30_43);
    drain(0);
    chk("frames_c", frames, 4);

    push_frame(48'h20_32_33_2E_35_43);
    push_frame(48'h20_33_30_2E_30_43);
    temperature = 16'h0235;
    n = 0;
    while (!(char_valid && char_pos == 3'd2) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("col2_timeout", n < 200, 1);
    char_ready = 1'b0;
    temperature = 16'h0300;
    repeat (S+4) @(posedge clk);
    #1;
    refresh = 1'b1;
    @(posedge clk);
    #1;
    refresh = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_busy", {31'd0, busy}, 1);
    drain(0);
    repeat (3*S) @(posedge clk);
    #1;
    chk("frames_d", frames, 6);
    chk_mm("mm_d", 16'h1057, 16'h0300);

    temperature = 16'h00AF;
    push_frame(48'h20_2D_2D_2E_2D_43);
    drain(0);
    chk("frames_e", frames, 7);
    chk_mm("mm_inv", 16'h1057, 16'h0300);

    @(negedge clk);
    temperature = 16'h0235;
    rst_n = 1'b0;
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(48'h20_32_33_2E_35_43);
    drain(0);
    temperature = 16'h1050;
    push_frame(48'h2D_20_35_2E_30_43);
    drain(0);
    chk_mm("mm_f", 16'h1050, 16'h0235);
    temperature = 16'h0310;
    push_frame(48'h20_33_31_2E_30_43);
    drain(0);
    chk("frames_f", frames, 10);
    chk_mm("mm_g", 16'h1050, 16'h0310);

    char_ready = 1'b0;
    temperature = 16'h0235;
    n = 0;
    while (!char_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_timeout", n < 200, 1);
    chk("mid_busy", {31'd0, busy}, 1);
    f0 = frames;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("mid_nodone", frames, f0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temp_text_formatter.md
Name: temp_text_formatter

Overview:
- Downstream consumer of the DS18B20 driver's 16-bit BCD temperature word.
- Filters the word so only a stable value is taken, then turns it into a fixed 6-character ASCII field.
- Streams the field to the LCD text renderer one character at a time over a valid/ready handshake.
- Optionally tracks the minimum and maximum accepted temperatures.

Parameters:
- STABLE_CYCLES, 27000: consecutive identical clk samples required before a value is accepted (1 ms at 27 MHz); legal range 2 to 2^CNT_W.
- CNT_W, 15: width of the stability counter.

Ports:
- clk  in  1  system clock, 27 MHz
- rst_n  in  1  asynchronous active-low reset
- temperature  in  16  BCD word: [15:12] sign (1 = negative), [11:8] tens, [7:4] units, [3:0] tenths
- refresh  in  1  one-cycle pulse; forces re-emission of the current accepted value
- char_data  out  8  ASCII character
- char_pos  out  3  column 0..5 of char_data
- char_valid  out  1  char_data/char_pos are valid
- char_ready  in  1  renderer accepts the character when asserted together with char_valid
- frame_done  out  1  one-cycle pulse after column 5 is accepted
- busy  out  1  high while a frame is being emitted
- min_temp  out  16  lowest accepted value, same BCD format
- max_temp  out  16  highest accepted value, same BCD format

Interface rule (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values:
  - char_valid, frame_done, busy = 0; char_data = 8'h20; char_pos = 0; min_temp = max_temp = 0.
  - Internal: candidate = 0, accepted = 0, cnt = 0, pending = 0, have_value = 0.
- Stability filter (runs every cycle, in every state):
  - If temperature != candidate: candidate <= temperature, cnt <= 0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
  - On the cycle cnt reaches STABLE_CYCLES-1, the value is accepted if candidate != accepted or have_value == 0. Acceptance sets accepted <= candidate, pending <= 1, have_value <= 1.
  - A value is accepted once only; it is not re-accepted while it stays constant.
  - Latency from the input settling to acceptance is STABLE_CYCLES cycles.
- refresh: sets pending <= 1 if have_value == 1; ignored while have_value == 0.
- FSM states IDLE, EMIT, DONE:
  - IDLE, pending == 1: snap <= accepted, pending <= 0, char_pos <= 0, go to EMIT. char_valid rises on the next cycle.
  - EMIT: char_valid = 1, busy = 1. char_data and char_pos hold stable until char_valid && char_ready.
    - On a handshake with char_pos < 5: char_pos increments.
    - On a handshake with char_pos == 5: char_valid <= 0, go to DONE.
  - DONE: frame_done = 1 for exactly one cycle, then go to IDLE.
  - Acceptance or refresh during EMIT/DONE only sets pending. The current frame always renders snap; the next frame starts from IDLE.
- Character mapping of snap, columns 0..5:
  - Column 0: sign, '-' (0x2D) if the sign nibble is 1, otherwise ' ' (0x20).
  - Column 1: tens digit, replaced by ' ' when tens == 0.
  - Column 2: units digit.
  - Column 3: '.'.
  - Column 4: tenths digit.
  - Column 5: 'C'.
  - A digit d is encoded as 8'h30 + d.
- Invalid word: any digit nibble > 9, or a sign nibble other than 0 or 1. The frame is then " --.-C" (0x20 0x2D 0x2D 0x2E 0x2D 0x43). Invalid words are accepted and displayed but never update min/max.
- char_data is registered; there is no combinational path from temperature to any output.
- Reset mid-frame: outputs return to their reset values immediately; no frame_done pulse is generated.

Optional Feature:
- Macro: TEMP_MINMAX_EN.
- When defined:
  - On each valid acceptance, compute the signed value v = ±(tens*100 + units*10 + tenths), 11-bit signed.
  - The first valid acceptance loads both min_temp and max_temp with the word.
  - After that: if v < min, min_temp <= word; if v > max, max_temp <= word.
  - -0.0 compares equal to +0.0; the stored word is not updated on a tie.
- When undefined: min_temp and max_temp are tied to 0 and no comparator logic is synthesized.

Test Plan:
- Reset, hold temperature = 16'h0235 for STABLE_CYCLES, char_ready = 1 → one frame of 0x20 '2' '3' '.' '5' 'C' on columns 0..5, then a single frame_done pulse; no second frame while the input is held.
- temperature = 16'h1057 with char_ready toggling 1/0 → frame "- 5.7C"; char_data and char_pos hold while ready is low; exactly 6 handshakes.
- Glitch: 0x0235 stable, then 0x0240 for STABLE_CYCLES-1 cycles, then back to 0x0235 → no new frame. 0x0240 held for a full STABLE_CYCLES → frame " 24.0C".
- Hold char_ready = 0 in column 2, input changes to 0x0300 and becomes stable, refresh also pulses → the current frame completes as " 23.5C", followed by exactly one further frame " 30.0C".
- temperature = 16'h00AF → frame " --.-C"; with TEMP_MINMAX_EN, min/max are unchanged.
- With TEMP_MINMAX_EN, accept in sequence 0x0235, 0x1050, 0x0310 → min_temp = 0x1050, max_temp = 0x0310. Assert rst_n low mid-frame → char_valid = 0, min_temp = max_temp = 0 asynchronously.
